// File: rtl/debounce_filter_multi.sv
// Multi-channel input debouncer: per-channel synchroniser and stability counter,
// registered rise/fall strobes, and a shared saturating count of rejected glitches.
module debounce_filter_multi #(
    parameter int CHANNELS      = 3,
    parameter int STABLE_CYCLES = 16,
    parameter int CNT_WIDTH     = 8,
    parameter int SYNC_STAGES   = 2,
    parameter int GLITCH_WIDTH  = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [CHANNELS-1:0]     in,
    input  logic                    glitch_clr,
    output logic [CHANNELS-1:0]     out,
    output logic [CHANNELS-1:0]     rise,
    output logic [CHANNELS-1:0]     fall,
    output logic [GLITCH_WIDTH-1:0] glitch_count
);

    localparam int EVW  = $clog2(CHANNELS + 1);
    localparam int SUMW = GLITCH_WIDTH + EVW;
    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(STABLE_CYCLES - 1);
    localparam logic [SUMW-1:0]      GMAX = SUMW'({GLITCH_WIDTH{1'b1}});

    logic [CHANNELS-1:0]     sync_q [SYNC_STAGES];
    logic [CHANNELS-1:0]     s;
    logic [CNT_WIDTH-1:0]    cnt_q  [CHANNELS];
    logic [CNT_WIDTH-1:0]    cnt_d  [CHANNELS];
    logic [CHANNELS-1:0]     out_d;
    logic [CHANNELS-1:0]     rise_d;
    logic [CHANNELS-1:0]     fall_d;
    logic [CHANNELS-1:0]     glitch_ev;
    logic [EVW-1:0]          ev_count;
    logic [SUMW-1:0]         gsum;
    logic [GLITCH_WIDTH-1:0] glitch_d;

    assign s = sync_q[SYNC_STAGES-1];

    // A counter that is non-zero while s agrees with out means the input
    // returned before committing: that is a rejected glitch.
    always_comb begin
        out_d     = out;
        rise_d    = '0;
        fall_d    = '0;
        glitch_ev = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_d[i] = '0;
            if (enable) begin
                if (s[i] != out[i]) begin
                    if (cnt_q[i] == LAST) begin
                        out_d[i]  = s[i];
                        rise_d[i] = s[i];
                        fall_d[i] = ~s[i];
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end else if (cnt_q[i] != '0) begin
                    glitch_ev[i] = 1'b1;
                end
            end
        end
    end

    // Saturating add of this cycle's glitch events; clear has priority.
    always_comb begin
        ev_count = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            ev_count = ev_count + EVW'(glitch_ev[i]);
        end
        gsum = SUMW'(glitch_count) + SUMW'(ev_count);
        if (glitch_clr) begin
            glitch_d = '0;
        end else if (gsum > GMAX) begin
            glitch_d = '1;
        end else begin
            glitch_d = gsum[GLITCH_WIDTH-1:0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= '0;
            end
            out          <= '0;
            rise         <= '0;
            fall         <= '0;
            glitch_count <= '0;
        end else begin
            sync_q[0] <= in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            out          <= out_d;
            rise         <= rise_d;
            fall         <= fall_d;
            glitch_count <= glitch_d;
        end
    end

endmodule

// File: tb/tb_debounce_filter_multi.sv
// Directed bench for debounce_filter_multi: default instance plus a 4-bit
// glitch-counter instance for saturation.
module tb_debounce_filter_multi;

    logic        clock;
    logic        reset;
    logic        enable;
    logic [2:0]  in;
    logic        glitchClr;
    logic [2:0]  out;
    logic [2:0]  rise;
    logic [2:0]  fall;
    logic [15:0] glitchCount;

    logic [2:0]  in4;
    logic        glitchClr4;
    logic [2:0]  out4;
    logic [2:0]  rise4;
    logic [2:0]  fall4;
    logic [3:0]  glitchCount4;

    int vectors = 0;
    int miscompares = 0;
    int fallCount;

    debounce_filter_multi dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .in           (in),
        .glitch_clr   (glitchClr),
        .out          (out),
        .rise         (rise),
        .fall         (fall),
        .glitch_count (glitchCount)
    );

    debounce_filter_multi #(.GLITCH_WIDTH(4)) dut4 (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .in           (in4),
        .glitch_clr   (glitchClr4),
        .out          (out4),
        .rise         (rise4),
        .fall         (fall4),
        .glitch_count (glitchCount4)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic [2:0] v, input int n);
        in = v;
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; in = 3'b111; glitchClr = 1'b0;
        in4 = 3'b000; glitchClr4 = 1'b0;

        // Reset held for 3 edges with inputs high
        for (int k = 0; k < 3; k++) tick();
        checkOutput("reset_out", 32'(out), 32'h0);
        checkOutput("reset_rise", 32'(rise), 32'h0);
        checkOutput("reset_fall", 32'(fall), 32'h0);
        checkOutput("reset_gc", 32'(glitchCount), 32'h0);

        // Release: out goes 111 on edge 18 with a single rise strobe
        reset = 1'b0;
        applyStimulus(3'b111, 17);
        checkOutput("edge17_out", 32'(out), 32'h0);
        tick();
        checkOutput("edge18_out", 32'(out), 32'h7);
        checkOutput("edge18_rise", 32'(rise), 32'h7);
        tick();
        checkOutput("edge19_rise", 32'(rise), 32'h0);
        checkOutput("edge19_out", 32'(out), 32'h7);

        // All channels back to 0
        applyStimulus(3'b000, 18);
        checkOutput("drop_out", 32'(out), 32'h0);
        checkOutput("drop_fall", 32'(fall), 32'h7);
        tick();
        checkOutput("drop_fall_end", 32'(fall), 32'h0);

        // 5-cycle pulse on in[0] is rejected and counted once
        for (int k = 0; k < 5; k++) begin
            applyStimulus(3'b001, 1);
            checkOutput("pulse5_out", 32'(out), 32'h0);
            checkOutput("pulse5_rise", 32'(rise), 32'h0);
        end
        for (int k = 0; k < 3; k++) begin
            applyStimulus(3'b000, 1);
            checkOutput("pulse5_out_tail", 32'(out), 32'h0);
        end
        checkOutput("pulse5_gc", 32'(glitchCount), 32'h1);

        // Bounce on in[1]: high 3, low 1, high 40
        applyStimulus(3'b010, 3);
        applyStimulus(3'b000, 1);
        for (int t = 1; t <= 40; t++) begin
            applyStimulus(3'b010, 1);
            if (t == 17) checkOutput("bounce_out17", 32'(out), 32'h0);
            if (t == 18) begin
                checkOutput("bounce_out18", 32'(out), 32'h2);
                checkOutput("bounce_rise18", 32'(rise), 32'h2);
            end
            if (t == 19) checkOutput("bounce_rise19", 32'(rise), 32'h0);
        end
        checkOutput("bounce_gc", 32'(glitchCount), 32'h2);

        // Drop in[1] for 40 cycles: exactly one fall strobe
        fallCount = 0;
        for (int t = 1; t <= 40; t++) begin
            applyStimulus(3'b000, 1);
            if (fall[1]) fallCount++;
            if (t == 18) begin
                checkOutput("fall1_out18", 32'(out), 32'h0);
                checkOutput("fall1_strobe18", 32'(fall), 32'h2);
            end
        end
        checkOutput("fall1_count", 32'(fallCount), 32'h1);
        checkOutput("fall1_gc", 32'(glitchCount), 32'h2);

        // Simultaneous 4-cycle pulses on in[0] and in[2]
        applyStimulus(3'b101, 4);
        applyStimulus(3'b000, 2);
        checkOutput("dual_gc_before", 32'(glitchCount), 32'h2);
        tick();
        checkOutput("dual_gc_after", 32'(glitchCount), 32'h4);
        checkOutput("dual_out", 32'(out), 32'h0);
        applyStimulus(3'b000, 3);

        // Same again with clear on the glitch edge
        applyStimulus(3'b101, 4);
        applyStimulus(3'b000, 2);
        glitchClr = 1'b1;
        tick();
        checkOutput("clr_wins_gc", 32'(glitchCount), 32'h0);
        glitchClr = 1'b0;
        tick();
        checkOutput("clr_after_gc", 32'(glitchCount), 32'h0);

        // 4-bit counter saturates at 15
        for (int p = 0; p < 20; p++) begin
            in4 = 3'b001;
            tick(); tick();
            in4 = 3'b000;
            for (int k = 0; k < 4; k++) tick();
            if (p == 13) checkOutput("sat_gc14", 32'(glitchCount4), 32'he);
        end
        checkOutput("sat_gc15", 32'(glitchCount4), 32'hf);
        checkOutput("sat_out", 32'(out4), 32'h0);
        checkOutput("sat_rise", 32'(rise4), 32'h0);
        glitchClr4 = 1'b1;
        tick();
        checkOutput("sat_clr", 32'(glitchCount4), 32'h0);
        glitchClr4 = 1'b0;

        // One glitch on in[2] so the count is non-zero
        applyStimulus(3'b100, 4);
        applyStimulus(3'b000, 4);
        checkOutput("pre_en_gc", 32'(glitchCount), 32'h1);

        // Disable 8 cycles into a pending change on in[0]
        applyStimulus(3'b001, 10);
        enable = 1'b0;
        applyStimulus(3'b001, 5);
        checkOutput("dis_out", 32'(out), 32'h0);
        checkOutput("dis_rise", 32'(rise), 32'h0);
        checkOutput("dis_gc", 32'(glitchCount), 32'h1);
        enable = 1'b1;
        applyStimulus(3'b001, 15);
        checkOutput("reen_out15", 32'(out), 32'h0);
        tick();
        checkOutput("reen_out16", 32'(out), 32'h1);
        checkOutput("reen_rise16", 32'(rise), 32'h1);
        checkOutput("reen_gc", 32'(glitchCount), 32'h1);

        // Reset in the middle of a pending fall
        applyStimulus(3'b000, 10);
        reset = 1'b1;
        tick();
        checkOutput("midrst_out", 32'(out), 32'h0);
        checkOutput("midrst_rise", 32'(rise), 32'h0);
        checkOutput("midrst_fall", 32'(fall), 32'h0);
        checkOutput("midrst_gc", 32'(glitchCount), 32'h0);
        reset = 1'b0;
        applyStimulus(3'b000, 20);
        checkOutput("postrst_out", 32'(out), 32'h0);
        checkOutput("postrst_fall", 32'(fall), 32'h0);
        checkOutput("postrst_gc", 32'(glitchCount), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/debounce_filter_multi.md
Name: debounce_filter_multi

Overview:
- Parametrised multi-channel successor to the single-bit debounce filter; used on encoder A/B/Z and switch inputs ahead of the quadrature decoder.
- Per channel: synchroniser, stability counter, filtered level, and one-cycle rise/fall strobes.
- Shared saturating glitch counter records rejected transitions for board diagnostics.

Parameters:
- CHANNELS, 3, number of independent input channels.
- STABLE_CYCLES, 16, consecutive synchronised samples that must differ from out before out changes; legal range 1..2^CNT_WIDTH.
- CNT_WIDTH, 8, width of each per-channel stability counter.
- SYNC_STAGES, 2, flip-flop synchroniser depth per channel; minimum 2.
- GLITCH_WIDTH, 16, width of the glitch counter.

Ports:
- clock  input  1  single system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  filter enable; low freezes out and clears counters.
- in  input  CHANNELS  raw asynchronous inputs.
- glitch_clr  input  1  synchronous clear of glitch_count.
- out  output  CHANNELS  debounced levels.
- rise  output  CHANNELS  one-cycle strobe when out[i] goes 0->1.
- fall  output  CHANNELS  one-cycle strobe when out[i] goes 1->0.
- glitch_count  output  GLITCH_WIDTH  saturating count of rejected transitions.

Behaviour:
- Interface decision: one clock; reset is synchronous and active-high.
- Reset: sync chains, counters, out, rise, fall and glitch_count all go to 0 on the first edge with reset=1. Reset mid-count discards the pending transition and counts no glitch. Reset overrides enable and glitch_clr.
- Synchroniser: in[i] passes through SYNC_STAGES flops to s[i]. It runs whenever reset=0, regardless of enable.
- Channel FSM, implicit in cnt[i]:
  - IDLE: s[i]==out[i]; cnt=0.
  - PENDING: s[i]!=out[i]; cnt increments each edge.
  - PENDING->commit: on the edge where s[i]!=out[i] and cnt==STABLE_CYCLES-1, out[i]<=s[i], cnt<=0, and rise[i] or fall[i] is 1 for exactly that one cycle.
  - PENDING->IDLE, s[i] reverts before commit: cnt<=0 and a glitch event is raised for channel i.
- Latency: if in[i] is held at a new value for N = SYNC_STAGES + STABLE_CYCLES consecutive edges (edge 1 is the first to sample it), out[i] updates on edge N. With the defaults, N=18 (360 ns at a 20 ns clock). Shorter pulses never reach out.
- STABLE_CYCLES=1: out follows s with one edge of delay; glitch events are impossible.
- enable=0: cnt is forced to 0, out holds, rise/fall are 0, and no glitch is counted. On re-enable the count restarts from 0.
- rise and fall are registered and never both high on the same channel. Strobes on different channels are independent and may coincide.
- Glitch counter:
  - Each edge, glitch_count increases by the number of channels raising a glitch event that cycle.
  - It saturates at 2^GLITCH_WIDTH-1 and never wraps.
  - glitch_clr=1 loads 0 and wins over simultaneous events.
- Channels are fully independent; there is no cross-channel interaction except the shared glitch counter.
- No combinational path from any input to any output.

Test Plan:
- Defaults, 20 ns clock. Hold reset=1 for 3 edges with in=3'b111 -> out=0, rise=0, fall=0, glitch_count=0. Release reset and keep in=111 -> out=111 on edge 18, rise=111 for exactly one cycle, then 0.
- in[0] high for 5 cycles, then low -> out[0] stays 0 and no strobe. glitch_count=1 within SYNC_STAGES+1 edges of the pulse end.
- in[1] bounces: high 3 cycles, low 1, high 40 -> glitch_count increments by 1. out[1] rises 18 edges after the final rising edge of in[1]. Then drop in[1] for 40 cycles -> fall[1] is a single one-cycle pulse.
- Identical 4-cycle pulses on in[0] and in[2] -> glitch_count increments by 2 in one edge. Repeat with glitch_clr asserted on that edge -> glitch_count=0.
- GLITCH_WIDTH=4: apply 20 short pulses -> glitch_count stops at 15. Then assert glitch_clr -> 0.
- Drop enable 8 cycles into a pending change, hold 5 cycles, then restore -> out holds and glitch_count is unchanged. out updates STABLE_CYCLES edges after re-enable. Assert reset mid-count -> all outputs 0 on the next edge.
